// File: rtl/ttt_pkg.sv
// Shared types for the tic-tac-toe controller: cell codes, board layout,
// controller states and small helpers for building cells and boards.
package ttt_pkg;

    // bit1 = occupied, bit0 = owner (0 = X, 1 = O)
    typedef enum logic [1:0] {
        EMPTY = 2'b00,
        X     = 2'b10,
        O     = 2'b11
    } cell_t;

    typedef cell_t [8:0] board_t;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WAIT_MOVE = 2'd1,
        CHECK     = 2'd2,
        GAME_OVER = 2'd3
    } ctrl_state_t;

    typedef enum logic {
        PLAYER_X = 1'b0,
        PLAYER_O = 1'b1
    } player_t;

    localparam logic [3:0] LAST_CELL = 4'd8;

    function automatic cell_t player_cell(input logic player);
        return player ? O : X;
    endfunction

    function automatic board_t empty_board();
        board_t b;
        for (int i = 0; i < 9; i++) begin
            b[i] = EMPTY;
        end
        return b;
    endfunction

endpackage

// File: rtl/ttt_turn_timer.sv
// Per-turn down-counter. expire_o flags the last cycle of a turn (count == 1);
// the owner decides whether that cycle actually counts down.
module ttt_turn_timer #(
    parameter int unsigned  TURN_TIMEOUT = 50_000_000,
    localparam int unsigned CW           = $clog2(TURN_TIMEOUT + 1)
) (
    input  logic          clk_i,
    input  logic          rst_n_i,
    input  logic          load_i,
    input  logic          en_i,
    output logic          expire_o,
    output logic [CW-1:0] count_o
);

    logic [CW-1:0] count_q;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            count_q <= '0;
        end else if (load_i) begin
            count_q <= CW'(TURN_TIMEOUT);
        end else if (en_i && (count_q != '0)) begin
            count_q <= count_q - CW'(1);
        end
    end

    assign expire_o = (count_q == CW'(1));
    assign count_o  = count_q;

endmodule

// File: rtl/ttt_turn_controller.sv
// Tic-tac-toe match sequencer: owns the board, takes one move per turn,
// rejects illegal moves, samples the end detector and enforces a turn timeout.
module ttt_turn_controller
    import ttt_pkg::*;
#(
    parameter int unsigned  TURN_TIMEOUT = 50_000_000,
    parameter logic         FIRST_PLAYER = 1'b0,
    localparam int unsigned TW           = $clog2(TURN_TIMEOUT + 1)
) (
    input  logic            clk_i,
    input  logic            rst_n_i,
    input  logic            start_i,
    input  logic            move_valid_i,
    input  logic [3:0]      move_pos_i,
    output logic            move_ready_o,
    output logic            move_reject_o,
    output logic [8:0][1:0] board_o,
    output logic            turn_o,
    input  logic            game_end_i,
    input  logic            tie_i,
    input  logic            winner_i,
    output logic            game_over_o,
    output logic            tie_o,
    output logic            winner_o,
    output logic            timeout_o,
    output logic [TW-1:0]   time_left_o,
    output logic [1:0]      state_o
);

    ctrl_state_t   state_q, state_d;
    board_t        board_q;
    logic          turn_q;
    logic          game_over_q, tie_q, winner_q;
    logic          reject_q, timeout_q;
    logic          pos_legal, move_accept, move_bad;
    logic          timer_en, timer_load, timer_expire, timeout_fire;
    logic          end_turn, latch_verdict;
    logic [TW-1:0] time_left;

    assign pos_legal = (move_pos_i <= LAST_CELL) && (board_q[move_pos_i] == EMPTY);

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Handshake: a move transfers on a rising edge where move_valid_i and
    // move_ready_o are both high; ready is only offered in WAIT_MOVE and is
    // withdrawn while start_i is high so a restart always wins over a move.
    always_comb begin
        state_d       = state_q;
        move_ready_o  = 1'b0;
        move_accept   = 1'b0;
        move_bad      = 1'b0;
        timer_en      = 1'b0;
        end_turn      = 1'b0;
        latch_verdict = 1'b0;
        case (state_q)
            WAIT_MOVE: begin
                move_ready_o = ~start_i;
                if (move_valid_i && !start_i) begin
                    if (pos_legal) begin
                        move_accept = 1'b1;
                        state_d     = CHECK;
                    end else begin
                        move_bad = 1'b1;
                    end
                end
                timer_en = ~move_accept & ~start_i;
            end
            CHECK: begin
                if (game_end_i) begin
                    latch_verdict = 1'b1;
                    state_d       = GAME_OVER;
                end else begin
                    end_turn = 1'b1;
                    state_d  = WAIT_MOVE;
                end
            end
            IDLE, GAME_OVER: state_d = state_q;
            default:         state_d = IDLE;
        endcase
        if (start_i) begin
            state_d       = WAIT_MOVE;
            end_turn      = 1'b0;
            latch_verdict = 1'b0;
        end
    end

    // An accepted move suppresses timer_en, so it beats a same-cycle expiry.
    assign timeout_fire = timer_en & timer_expire;
    assign timer_load   = start_i | timeout_fire | end_turn;

    ttt_turn_timer #(
        .TURN_TIMEOUT(TURN_TIMEOUT)
    ) u_timer (
        .clk_i   (clk_i),
        .rst_n_i (rst_n_i),
        .load_i  (timer_load),
        .en_i    (timer_en),
        .expire_o(timer_expire),
        .count_o (time_left)
    );

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            board_q     <= empty_board();
            turn_q      <= FIRST_PLAYER;
            game_over_q <= 1'b0;
            tie_q       <= 1'b0;
            winner_q    <= 1'b0;
            reject_q    <= 1'b0;
            timeout_q   <= 1'b0;
        end else begin
            reject_q  <= move_bad;
            timeout_q <= timeout_fire;
            if (start_i) begin
                board_q     <= empty_board();
                turn_q      <= FIRST_PLAYER;
                game_over_q <= 1'b0;
                tie_q       <= 1'b0;
                winner_q    <= 1'b0;
            end else begin
                if (move_accept) begin
                    board_q[move_pos_i] <= player_cell(turn_q);
                end
                if (timeout_fire || end_turn) begin
                    turn_q <= ~turn_q;
                end
                if (latch_verdict) begin
                    game_over_q <= 1'b1;
                    tie_q       <= tie_i;
                    winner_q    <= winner_i;
                end
            end
        end
    end

    assign board_o       = board_q;
    assign turn_o        = turn_q;
    assign move_reject_o = reject_q;
    assign timeout_o     = timeout_q;
    assign game_over_o   = game_over_q;
    assign tie_o         = tie_q;
    assign winner_o      = winner_q;
    assign time_left_o   = time_left;
    assign state_o       = state_q;

endmodule
